ysyx_25050147_ifu: RTL and testbench
====================================

Name: ysyx_25050147_ifu

Overview:
Multi-cycle instruction fetch unit directly upstream of the IDU/EXU datapath. It replaces the free-running `mem` instruction input with a handshaked memory read channel (AR/R style). It holds the PC and issues one fetched instruction, plus its PC, to the decode stage per valid/ready handshake. It then waits for the next PC (dnpc) from the core before fetching again.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
XLEN, 32, address and instruction width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous reset, active-low (asserted when 0)
ifu_araddr  out  XLEN  fetch address, equals pc
ifu_arvalid  out  1  read request valid
ifu_arready  in  1  memory accepts request
ifu_rdata  in  XLEN  returned instruction word
ifu_rresp  in  2  response code, 0 = OKAY, anything else = access fault
ifu_rvalid  in  1  response valid
ifu_rready  out  1  IFU accepts response
inst_valid  out  1  instruction available to IDU
inst_ready  in  1  IDU consumes instruction
inst  out  XLEN  registered instruction word
inst_pc  out  XLEN  PC of inst
npc_valid  in  1  core presents next PC
npc  in  XLEN  next PC (dnpc)
fault  out  1  sticky fault flag
fault_cause  out  2  1 = bus access fault, 2 = misaligned npc
fault_pc  out  XLEN  offending address
fetch_cnt  out  32  number of instructions issued to IDU

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, fault=0, fault_cause=0, fault_pc=0, fetch_cnt=0. All handshake outputs are 0.
- State machine states: IDLE, FETCH, WAIT_R, ISSUE, WAIT_NPC, FAULT. Outputs decode from state: arvalid=(FETCH), rready=(WAIT_R), inst_valid=(ISSUE).
- IDLE: go to FETCH the next cycle unconditionally.
  - First arvalid therefore appears in the 2nd cycle after rst deasserts.
- FETCH: ifu_araddr=pc, held stable while arvalid=1 and arready=0.
  - arvalid&&arready at edge N: state becomes WAIT_R at N+1.
  - arvalid is never withdrawn before acceptance.
- WAIT_R: rready=1.
  - On rvalid && rresp==0: inst<=rdata, inst_pc<=pc, state becomes ISSUE.
  - On rvalid && rresp!=0: fault<=1, fault_cause<=1, fault_pc<=pc, state becomes FAULT.
  - A response arriving in the same cycle as request acceptance is not possible: rready is 0 in FETCH and rvalid is ignored there.
- ISSUE: inst_valid=1; inst and inst_pc are stable until the handshake completes.
  - inst_valid&&inst_ready: fetch_cnt<=fetch_cnt+1 (wraps modulo 2^32), state becomes WAIT_NPC.
- WAIT_NPC:
  - npc_valid with npc[1:0]==0: pc<=npc, state becomes FETCH.
  - npc_valid with npc[1:0]!=0: fault<=1, fault_cause<=2, fault_pc<=npc, state becomes FAULT.
  - npc_valid is ignored in every other state.
- FAULT: terminal. No further requests; all handshake outputs are 0. Leaves only through rst=0.
- Reset mid-operation (any state, including an outstanding AR or R): state returns to IDLE immediately.
  - Any later R beat from the abandoned request is dropped, because rready=0 until a new request is accepted.
- Latency with memory at zero wait:
  - arvalid in cycle 1, WAIT_R in cycle 2, ISSUE in cycle 3.
  - With inst_ready=1 and npc_valid in the next cycle, the next arvalid is in cycle 5.
  - Steady-state throughput: one instruction per 4 cycles.
- pc is modified only in IDLE/reset and WAIT_NPC.
- No combinational path from any input to any output.

Decomposition:
- Shared package ysyx_25050147_pkg holds:
  - the state encoding, 3-bit localparams S_IDLE..S_FAULT;
  - RESP_OKAY=2'b00;
  - the fault cause codes FC_NONE=0, FC_ACCESS=1, FC_MISALIGN=2;
  - the RESET_PC default.
- No sub-module is needed. Next-state logic, the datapath registers and fetch_cnt sit in one module.
- The PC uses the existing Reg primitive, with the enable driven by the reset/WAIT_NPC load condition.

Test Plan:
- Reset then zero-wait memory returning 32'h00000413 with rresp=0:
  - araddr=32'h80000000 with arvalid in the 2nd cycle after reset release;
  - inst_valid with inst=32'h00000413 and inst_pc=32'h80000000 two cycles later.
- arready held 0 for 3 cycles, then inst_ready held 0 for 4 cycles:
  - araddr and arvalid stay stable throughout the stall;
  - inst and inst_pc stay unchanged while stalled;
  - fetch_cnt increments exactly once.
- Three fetches with npc=32'h80000004, then 32'h80000010, then 32'h80000000:
  - araddr follows the npc sequence;
  - fetch_cnt=3;
  - npc_valid pulses sent during ISSUE are ignored.
- Response with rresp=2'b10 at pc=32'h80000008:
  - fault=1, fault_cause=1, fault_pc=32'h80000008;
  - no arvalid afterwards.
- npc=32'h80000002:
  - fault=1, fault_cause=2, fault_pc=32'h80000002;
  - no arvalid afterwards.
- rst=0 asserted while in WAIT_R, then a late rvalid arrives:
  - outputs return to reset values immediately;
  - the late beat is dropped;
  - the next fetch is from 32'h80000000 with fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_25050147_pkg.sv
// Shared definitions for the ysyx_25050147 core: IFU state encoding,
// bus response codes, fault cause codes and reset defaults.
package ysyx_25050147_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_R   = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_NPC = 3'd4,
    S_FAULT    = 3'd5
  } ifu_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ACCESS   = 2'd1;
  localparam logic [1:0] FC_MISALIGN = 2'd2;

endpackage

// File: rtl/ysyx_25050147_ifu_reg.sv
// Generic enabled register primitive with asynchronous active-low reset.
module Reg #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_25050147_ifu.sv
// Multi-cycle instruction fetch unit: one AR/R read per instruction, issues
// inst/inst_pc to decode, then waits for dnpc before fetching again.
module ysyx_25050147_ifu
  import ysyx_25050147_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] ifu_araddr,
  output logic            ifu_arvalid,
  input  logic            ifu_arready,
  input  logic [XLEN-1:0] ifu_rdata,
  input  logic [1:0]      ifu_rresp,
  input  logic            ifu_rvalid,
  output logic            ifu_rready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     fetch_cnt
);

  ifu_state_t      state, state_n;
  logic [XLEN-1:0] pc;
  logic            npc_aligned;
  logic            resp_okay;
  logic            r_fire;
  logic            npc_fire;
  logic            issue_fire;
  logic            pc_load;

  assign npc_aligned = (npc[1:0] == 2'b00);
  assign resp_okay   = (ifu_rresp == RESP_OKAY);
  assign r_fire      = (state == S_WAIT_R)   && ifu_rvalid;
  assign npc_fire    = (state == S_WAIT_NPC) && npc_valid;
  assign issue_fire  = (state == S_ISSUE)    && inst_ready;
  assign pc_load     = npc_fire && npc_aligned;

  // Handshake outputs decode purely from the state register.
  assign ifu_arvalid = (state == S_FETCH);
  assign ifu_rready  = (state == S_WAIT_R);
  assign inst_valid  = (state == S_ISSUE);
  assign ifu_araddr  = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     state_n = S_FETCH;
      S_FETCH:    if (ifu_arready) state_n = S_WAIT_R;
      S_WAIT_R:   if (ifu_rvalid) state_n = resp_okay ? S_ISSUE : S_FAULT;
      S_ISSUE:    if (inst_ready) state_n = S_WAIT_NPC;
      S_WAIT_NPC: if (npc_valid) state_n = npc_aligned ? S_FETCH : S_FAULT;
      S_FAULT:    state_n = S_FAULT;
      default:    state_n = S_IDLE;
    endcase
  end

  Reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .din  (npc),
    .dout (pc),
    .wen  (pc_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst        <= '0;
      inst_pc     <= '0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_pc    <= '0;
      fetch_cnt   <= '0;
    end else begin
      if (r_fire && resp_okay) begin
        inst    <= ifu_rdata;
        inst_pc <= pc;
      end
      if (r_fire && !resp_okay) begin
        fault       <= 1'b1;
        fault_cause <= FC_ACCESS;
        fault_pc    <= pc;
      end
      if (npc_fire && !npc_aligned) begin
        fault       <= 1'b1;
        fault_cause <= FC_MISALIGN;
        fault_pc    <= npc;
      end
      if (issue_fire) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// Self-checking bench for ysyx_25050147_ifu: a memory model drives AR/R and a
// scoreboard queue holds the {inst, pc} expected at each issue.
module tb_ysyx_25050147_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  ysyx_25050147_ifu #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .npc_valid   (npc_valid),
    .npc         (npc),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_pc    (fault_pc),
    .fetch_cnt   (fetch_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_halted(input string tag);
    for (int i = 0; i < 5; i++) begin
      step;
      check_eq({tag, "_no_ar"}, ifu_arvalid, 0);
      check_eq({tag, "_no_r"}, ifu_rready, 0);
      check_eq({tag, "_no_iv"}, inst_valid, 0);
    end
  endtask

  task automatic do_reset;
    rst         = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    inst_ready  = 1'b0;
    npc_valid   = 1'b0;
    npc         = '0;
    step;
    step;
    check_eq("rst_arvalid", ifu_arvalid, 0);
    check_eq("rst_rready", ifu_rready, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_fault_cause", fault_cause, 0);
    check_eq("rst_fault_pc", fault_pc, 32'h0);
    check_eq("rst_fetch_cnt", fetch_cnt, 32'h0);
    check_eq("rst_araddr", ifu_araddr, 32'h8000_0000);
    exp_cnt = 32'h0;
    sb_q.delete();
    rst = 1'b1;
    check_eq("idle_no_ar", ifu_arvalid, 0);
    step;
    check_eq("ar_2nd_cycle", ifu_arvalid, 1);
  endtask

  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word,
                          input logic [1:0] rresp, input int ar_wait, input int r_wait,
                          input int issue_wait, input bit pulse_npc,
                          input logic [31:0] next_npc);
    int          n;
    logic [63:0] exp_e;
    n = 0;
    while (!ifu_arvalid && n < 20) begin
      step;
      n++;
    end
    check_eq("ar_seen", ifu_arvalid, 1);
    if (!ifu_arvalid) return;
    check_eq("araddr", ifu_araddr, exp_pc);
    for (int i = 0; i < ar_wait; i++) begin
      step;
      check_eq("ar_hold", ifu_arvalid, 1);
      check_eq("ar_stable", ifu_araddr, exp_pc);
    end
    ifu_arready = 1'b1;
    if (rresp == 2'b00) sb_q.push_back({word, exp_pc});
    step;
    ifu_arready = 1'b0;
    check_eq("rready", ifu_rready, 1);
    check_eq("ar_drop", ifu_arvalid, 0);
    for (int i = 0; i < r_wait; i++) begin
      step;
      check_eq("rready_hold", ifu_rready, 1);
      check_eq("r_no_iv", inst_valid, 0);
    end
    ifu_rvalid = 1'b1;
    ifu_rdata  = word;
    ifu_rresp  = rresp;
    step;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_rresp  = 2'b00;
    if (rresp != 2'b00) begin
      check_eq("acc_fault", fault, 1);
      check_eq("acc_cause", fault_cause, 1);
      check_eq("acc_fault_pc", fault_pc, exp_pc);
      check_halted("acc");
      return;
    end
    check_eq("issue_lat", inst_valid, 1);
    check_eq("sb_size", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    exp_e = sb_q.pop_front();
    check_eq("inst", inst, exp_e[63:32]);
    check_eq("inst_pc", inst_pc, exp_e[31:0]);
    if (pulse_npc) begin
      npc_valid = 1'b1;
      npc       = 32'h0000_0002;
    end
    for (int i = 0; i < issue_wait; i++) begin
      step;
      check_eq("iv_hold", inst_valid, 1);
      check_eq("inst_stable", inst, exp_e[63:32]);
      check_eq("inst_pc_stable", inst_pc, exp_e[31:0]);
      check_eq("cnt_stall", fetch_cnt, exp_cnt);
    end
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    check_eq("iv_drop", inst_valid, 0);
    check_eq("fetch_cnt", fetch_cnt, exp_cnt);
    check_eq("npc_ignored", fault, 0);
    npc_valid = 1'b1;
    npc       = next_npc;
    step;
    npc_valid = 1'b0;
    if (next_npc[1:0] != 2'b00) begin
      check_eq("mis_fault", fault, 1);
      check_eq("mis_cause", fault_cause, 2);
      check_eq("mis_fault_pc", fault_pc, next_npc);
      check_halted("mis");
    end else begin
      check_eq("ar_next", ifu_arvalid, 1);
      check_eq("araddr_next", ifu_araddr, next_npc);
      check_eq("no_fault", fault, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic zero-wait fetch, then stalled handshakes, then the npc sequence.
    do_reset;
    do_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0004);
    do_fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 3, 1, 4, 1'b1, 32'h8000_0010);
    do_fetch(32'h8000_0010, 32'h0020_0113, 2'b00, 0, 0, 1, 1'b1, 32'h8000_0000);
    check_eq("cnt_three", fetch_cnt, 32'd3);
    do_fetch(32'h8000_0000, 32'h0030_0193, 2'b00, 1, 0, 0, 1'b0, 32'h8000_0008);
    do_fetch(32'h8000_0008, 32'hFFFF_FFFF, 2'b10, 0, 2, 0, 1'b0, 32'h0);

    do_reset;
    do_fetch(32'h8000_0000, 32'h0040_0213, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0002);

    // Asynchronous reset while a read response is outstanding.
    do_reset;
    do_fetch(32'h8000_0000, 32'h0050_0513, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0004);
    ifu_arready = 1'b1;
    step;
    ifu_arready = 1'b0;
    check_eq("mid_rready", ifu_rready, 1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rready", ifu_rready, 0);
    check_eq("mid_rst_arvalid", ifu_arvalid, 0);
    check_eq("mid_rst_inst", inst, 32'h0);
    check_eq("mid_rst_inst_pc", inst_pc, 32'h0);
    check_eq("mid_rst_cnt", fetch_cnt, 32'h0);
    check_eq("mid_rst_araddr", ifu_araddr, 32'h8000_0000);
    step;
    rst        = 1'b1;
    exp_cnt    = 32'h0;
    ifu_rvalid = 1'b1;
    ifu_rdata  = 32'hDEAD_BEEF;
    step;
    check_eq("late_rready", ifu_rready, 0);
    check_eq("late_arvalid", ifu_arvalid, 1);
    check_eq("late_araddr", ifu_araddr, 32'h8000_0000);
    step;
    check_eq("late_still_fetch", ifu_arvalid, 1);
    check_eq("late_no_iv", inst_valid, 0);
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    check_eq("late_cnt", fetch_cnt, 32'h0);
    do_fetch(32'h8000_0000, 32'h0010_0093, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0004);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
